axi_lite_reg_slave: RTL and testbench

AXI4-Lite responder (slave end) terminating one s00 port from the NIC fabric in a bank of NUM_REGS software-visible DW-bit registers. Register contents and per-register write pulses are exported to core logic. It is the endpoint sitting behind a NIC master port such as m00.

---
 rtl/axi_lite_pkg.sv | 39 +++
 rtl/axi_lite_reg_bank.sv | 42 ++++
 rtl/axi_lite_reg_slave.sv | 174 +++++++++++++++++
 tb/tb_axi_lite_reg_slave.sv | 455 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register slave.
// Response codes, read FSM states, address/strobe helper functions.
package axi_lite_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } resp_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rstate_e;

    localparam int AXI_PROT_W = 3;
    localparam int MAX_DW     = 64;
    localparam int MAX_SW     = MAX_DW / 8;

    function automatic int addr_lsb(input int dw);
        return $clog2(dw / 8);
    endfunction

    // Byte-lane merge sized for the widest bus; callers truncate.
    function automatic logic [MAX_DW-1:0] strb_merge(
        input logic [MAX_DW-1:0] old_v,
        input logic [MAX_DW-1:0] new_v,
        input logic [MAX_SW-1:0] strb
    );
        logic [MAX_DW-1:0] r;
        r = old_v;
        for (int b = 0; b < MAX_SW; b++) begin
            if (strb[b]) r[b*8 +: 8] = new_v[b*8 +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/axi_lite_reg_bank.sv
// Strobe-write register storage with one write and one read port.
// Read data is combinational from the current (pre-write) contents.
module axi_lite_reg_bank
    import axi_lite_pkg::*;
#(
    parameter int DW = 32,
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic            clock,
    input  logic            resetn,
    input  logic            we_i,
    input  logic [IW-1:0]   widx_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic [DW/8-1:0] wstrb_i,
    input  logic [IW-1:0]   ridx_i,
    output logic [DW-1:0]   rd_o,
    output logic [N*DW-1:0] q_o
);

    logic [DW-1:0]     mem_q [N];
    logic [MAX_DW-1:0] mem_d;

    assign mem_d = strb_merge(MAX_DW'(mem_q[widx_i]),
                              MAX_DW'(wdata_i),
                              MAX_SW'(wstrb_i));

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < N; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[widx_i] <= mem_d[DW-1:0];
        end
    end

    assign rd_o = mem_q[ridx_i];

    for (genvar i = 0; i < N; i++) begin : g_flat
        assign q_o[i*DW +: DW] = mem_q[i];
    end

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite register slave: independent AW/W capture, B and R channels.
// Define AXI_LITE_REG_SLAVE_ERR_EN to answer out-of-range with SLVERR.
module axi_lite_reg_slave
    import axi_lite_pkg::*;
#(
    parameter int S00_AW   = 32,
    parameter int S00_DW   = 32,
    parameter int NUM_REGS = 16
) (
    input  logic                       clock,
    input  logic                       resetn,
    input  logic [S00_AW-1:0]          s00_axi_awaddr,
    input  logic [AXI_PROT_W-1:0]      s00_axi_awprot,
    input  logic                       s00_axi_awvalid,
    output logic                       s00_axi_awready,
    input  logic [S00_DW-1:0]          s00_axi_wdata,
    input  logic [S00_DW/8-1:0]        s00_axi_wstrb,
    input  logic                       s00_axi_wvalid,
    output logic                       s00_axi_wready,
    output logic [1:0]                 s00_axi_bresp,
    output logic                       s00_axi_bvalid,
    input  logic                       s00_axi_bready,
    input  logic [S00_AW-1:0]          s00_axi_araddr,
    input  logic [AXI_PROT_W-1:0]      s00_axi_arprot,
    input  logic                       s00_axi_arvalid,
    output logic                       s00_axi_arready,
    output logic [S00_DW-1:0]          s00_axi_rdata,
    output logic [1:0]                 s00_axi_rresp,
    output logic                       s00_axi_rvalid,
    input  logic                       s00_axi_rready,
    output logic [NUM_REGS*S00_DW-1:0] reg_q,
    output logic [NUM_REGS-1:0]        reg_wr_pulse
);

    localparam int LSB = addr_lsb(S00_DW);
    localparam int SW  = S00_DW / 8;
    localparam int IW  = $clog2(NUM_REGS);
    localparam int AIW = S00_AW - LSB;

    logic                ready_en_q;
    logic                aw_full_q;
    logic [AIW-1:0]      aw_idx_q;
    logic                w_full_q;
    logic [S00_DW-1:0]   w_data_q;
    logic [SW-1:0]       w_strb_q;
    logic                bvalid_q;
    resp_e               bresp_q;
    rstate_e             rstate_q;
    logic                rvalid_q;
    logic [S00_DW-1:0]   rdata_q;
    resp_e               rresp_q;
    logic [NUM_REGS-1:0] pulse_q;

    logic [AIW-1:0]    ar_idx;
    logic              aw_hit, ar_hit;
    logic              aw_hs, w_hs, ar_hs, commit;
    resp_e             wr_resp, rd_resp;
    logic [S00_DW-1:0] bank_rd;
    logic              unused_ok;

    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[LSB-1:0],
                         s00_axi_araddr[LSB-1:0]};

    assign ar_idx = s00_axi_araddr[S00_AW-1:LSB];
    assign aw_hit = aw_idx_q < AIW'(NUM_REGS);
    assign ar_hit = ar_idx < AIW'(NUM_REGS);

`ifdef AXI_LITE_REG_SLAVE_ERR_EN
    assign wr_resp = aw_hit ? OKAY : SLVERR;
    assign rd_resp = ar_hit ? OKAY : SLVERR;
`else
    assign wr_resp = OKAY;
    assign rd_resp = OKAY;
`endif

    assign s00_axi_awready = ready_en_q & ~aw_full_q;
    assign s00_axi_wready  = ready_en_q & ~w_full_q;
    assign s00_axi_arready = ready_en_q & (rstate_q == R_IDLE);

    assign aw_hs  = s00_axi_awvalid & s00_axi_awready;
    assign w_hs   = s00_axi_wvalid & s00_axi_wready;
    assign ar_hs  = s00_axi_arvalid & s00_axi_arready;
    // A pending B only blocks the next commit if it is not draining now.
    assign commit = aw_full_q & w_full_q & (~bvalid_q | s00_axi_bready);

    axi_lite_reg_bank #(
        .DW (S00_DW),
        .N  (NUM_REGS),
        .IW (IW)
    ) u_bank (
        .clock   (clock),
        .resetn  (resetn),
        .we_i    (commit & aw_hit),
        .widx_i  (aw_idx_q[IW-1:0]),
        .wdata_i (w_data_q),
        .wstrb_i (w_strb_q),
        .ridx_i  (ar_idx[IW-1:0]),
        .rd_o    (bank_rd),
        .q_o     (reg_q)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ready_en_q <= 1'b0;
            aw_full_q  <= 1'b0;
            aw_idx_q   <= '0;
            w_full_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= OKAY;
            pulse_q    <= '0;
        end else begin
            ready_en_q <= 1'b1;
            if (commit) begin
                aw_full_q <= 1'b0;
            end else if (aw_hs) begin
                aw_full_q <= 1'b1;
                aw_idx_q  <= s00_axi_awaddr[S00_AW-1:LSB];
            end
            if (commit) begin
                w_full_q <= 1'b0;
            end else if (w_hs) begin
                w_full_q <= 1'b1;
                w_data_q <= s00_axi_wdata;
                w_strb_q <= s00_axi_wstrb;
            end
            pulse_q <= '0;
            if (commit & aw_hit) pulse_q[aw_idx_q[IW-1:0]] <= 1'b1;
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= wr_resp;
            end else if (s00_axi_bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rstate_q <= R_IDLE;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= OKAY;
        end else begin
            unique case (rstate_q)
                R_IDLE: begin
                    if (ar_hs) begin
                        rstate_q <= R_RESP;
                        rvalid_q <= 1'b1;
                        rdata_q  <= ar_hit ? bank_rd : '0;
                        rresp_q  <= rd_resp;
                    end
                end
                R_RESP: begin
                    if (s00_axi_rready) begin
                        rstate_q <= R_IDLE;
                        rvalid_q <= 1'b0;
                    end
                end
                default: rstate_q <= R_IDLE;
            endcase
        end
    end

    assign s00_axi_bvalid = bvalid_q;
    assign s00_axi_bresp  = bresp_q;
    assign s00_axi_rvalid = rvalid_q;
    assign s00_axi_rdata  = rdata_q;
    assign s00_axi_rresp  = rresp_q;
    assign reg_wr_pulse   = pulse_q;

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Self-checking bench for axi_lite_reg_slave (32-bit, 16 registers).
// Reference model: plain register array updated by byte-strobe rules.
module tb_axi_lite_reg_slave;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int N  = 16;

`ifdef AXI_LITE_REG_SLAVE_ERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    logic            clock = 1'b0;
    logic            resetn = 1'b0;
    logic [AW-1:0]   awaddr = '0;
    logic [2:0]      awprot = '0;
    logic            awvalid = 1'b0;
    logic            awready;
    logic [DW-1:0]   wdata = '0;
    logic [DW/8-1:0] wstrb = '0;
    logic            wvalid = 1'b0;
    logic            wready;
    logic [1:0]      bresp;
    logic            bvalid;
    logic            bready = 1'b1;
    logic [AW-1:0]   araddr = '0;
    logic [2:0]      arprot = '0;
    logic            arvalid = 1'b0;
    logic            arready;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rvalid;
    logic            rready = 1'b0;
    logic [N*DW-1:0] reg_q;
    logic [N-1:0]    reg_wr_pulse;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] model [N];

    always #5 clock = ~clock;

    axi_lite_reg_slave #(
        .S00_AW   (AW),
        .S00_DW   (DW),
        .NUM_REGS (N)
    ) dut (
        .clock           (clock),
        .resetn          (resetn),
        .s00_axi_awaddr  (awaddr),
        .s00_axi_awprot  (awprot),
        .s00_axi_awvalid (awvalid),
        .s00_axi_awready (awready),
        .s00_axi_wdata   (wdata),
        .s00_axi_wstrb   (wstrb),
        .s00_axi_wvalid  (wvalid),
        .s00_axi_wready  (wready),
        .s00_axi_bresp   (bresp),
        .s00_axi_bvalid  (bvalid),
        .s00_axi_bready  (bready),
        .s00_axi_araddr  (araddr),
        .s00_axi_arprot  (arprot),
        .s00_axi_arvalid (arvalid),
        .s00_axi_arready (arready),
        .s00_axi_rdata   (rdata),
        .s00_axi_rresp   (rresp),
        .s00_axi_rvalid  (rvalid),
        .s00_axi_rready  (rready),
        .reg_q           (reg_q),
        .reg_wr_pulse    (reg_wr_pulse)
    );

    function automatic bit in_range(logic [AW-1:0] a);
        return (a >> 2) < N;
    endfunction

    function automatic int idx_of(logic [AW-1:0] a);
        return int'((a >> 2) & 32'hF);
    endfunction

    function automatic void model_write(logic [AW-1:0] a, logic [DW-1:0] d,
                                        logic [3:0] s);
        if (in_range(a)) begin
            for (int b = 0; b < 4; b++)
                if (s[b]) model[idx_of(a)][b*8 +: 8] = d[b*8 +: 8];
        end
    endfunction

    function automatic logic [N-1:0] exp_pulse(logic [AW-1:0] a);
        logic [N-1:0] p;
        p = '0;
        if (in_range(a)) p[idx_of(a)] = 1'b1;
        return p;
    endfunction

    function automatic logic [N*DW-1:0] model_flat();
        logic [N*DW-1:0] f;
        for (int i = 0; i < N; i++) f[i*DW +: DW] = model[i];
        return f;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 7) == 0)
            return 32'h0100_0000 | AW'($urandom_range(0, 255));
        return AW'($urandom_range(0, N + 2) * 4 + $urandom_range(0, 3));
    endfunction

    // Drives one write; W leads AW by 'lead' cycles (negative: AW leads).
    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [3:0] s, input int lead,
                            input int bdelay,
                            output logic [1:0] resp,
                            output logic [N-1:0] pulse,
                            output logic [N-1:0] pnext,
                            output logic [N*DW-1:0] qseen,
                            output int lat, output int nb,
                            output bit tmo);
        int t = 0, post = 0, hold = 0;
        int aw_at = (lead > 0) ? lead : 0;
        int w_at = (lead < 0) ? -lead : 0;
        bit awd = 0, wd = 0, seen = 0, awon = 0, won = 0;
        bit hsaw, hsw, hsb;
        resp = 'x; pulse = 'x; pnext = 'x; qseen = 'x;
        lat = -1; nb = 0;
        bready = 1'b0;
        while (t < 80 && post < 3) begin
            if (!awon && t >= aw_at) begin
                awon = 1; awvalid = 1'b1; awaddr = a;
            end
            if (!won && t >= w_at) begin
                won = 1; wvalid = 1'b1; wdata = d; wstrb = s;
            end
            if (seen && t == lat + 1) pnext = reg_wr_pulse;
            if (bvalid && !seen) begin
                seen = 1; lat = t; resp = bresp;
                pulse = reg_wr_pulse; qseen = reg_q; hold = bdelay;
            end
            bready = seen && hold == 0;
            if (seen && hold > 0) hold--;
            hsaw = awvalid & awready;
            hsw = wvalid & wready;
            hsb = bvalid & bready;
            @(negedge clock);
            t++;
            if (hsaw) begin awvalid = 1'b0; awd = 1; end
            if (hsw) begin wvalid = 1'b0; wd = 1; end
            if (hsb) nb++;
            if (nb > 0) post++;
        end
        awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
        tmo = !awd || !wd || nb == 0;
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int rdelay,
                           output logic [DW-1:0] d, output logic [1:0] resp,
                           output int lat, output bit stable,
                           output logic after_rv, output logic after_ar,
                           output bit tmo);
        int t = 0, hold = 0;
        bit seen = 0, done = 0, hsar, hsr;
        d = 'x; resp = 'x; lat = -1; stable = 1;
        after_rv = 'x; after_ar = 'x;
        arvalid = 1'b1; araddr = a; rready = 1'b0;
        while (t < 80 && !done) begin
            if (rvalid && !seen) begin
                seen = 1; d = rdata; resp = rresp; lat = t; hold = rdelay;
            end else if (seen) begin
                if (!rvalid || rdata !== d || rresp !== resp) stable = 0;
            end
            if (seen && arready) stable = 0;
            rready = seen && hold == 0;
            if (seen && hold > 0) hold--;
            hsar = arvalid & arready;
            hsr = rvalid & rready;
            @(negedge clock);
            t++;
            if (hsar) arvalid = 1'b0;
            if (hsr) begin
                done = 1; after_rv = rvalid; after_ar = arready;
            end
        end
        arvalid = 1'b0; rready = 1'b0;
        tmo = !done;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (3) @(negedge clock);
        checks++;
        if ({bvalid, rvalid, bresp, rresp} !== 6'b0) begin
            errors++;
            $display("FAIL reset_valid_resp got %b want 0",
                     {bvalid, rvalid, bresp, rresp});
        end
        checks++;
        if (rdata !== '0 || reg_wr_pulse !== '0 || reg_q !== '0) begin
            errors++;
            $display("FAIL reset_data got rdata %h pulse %h want 0",
                     rdata, reg_wr_pulse);
        end
        resetn = 1'b1;
        #1;
        checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            errors++;
            $display("FAIL reset_ready_first got %b want 000",
                     {awready, wready, arready});
        end
        @(negedge clock);
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL reset_ready_en got %b want 111",
                     {awready, wready, arready});
        end
    endtask

    task automatic test_same_cycle();
        logic [1:0] r; logic [N-1:0] p, pn; logic [N*DW-1:0] q;
        int lat, nb; bit tmo;
        do_write(32'h8, 32'hDEADBEEF, 4'hF, 0, 0, r, p, pn, q, lat, nb, tmo);
        model_write(32'h8, 32'hDEADBEEF, 4'hF);
        checks++;
        if (tmo || lat !== 2) begin
            errors++;
            $display("FAIL same_cycle_latency got %0d tmo %0d want 2", lat, tmo);
        end
        checks++;
        if (q[2*DW +: DW] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL same_cycle_reg2 got %h want deadbeef", q[2*DW +: DW]);
        end
        checks++;
        if (p !== 16'h0004 || pn !== 16'h0000) begin
            errors++;
            $display("FAIL same_cycle_pulse got %h then %h want 0004 then 0",
                     p, pn);
        end
        checks++;
        if (r !== 2'b00 || nb !== 1) begin
            errors++;
            $display("FAIL same_cycle_b got resp %b count %0d want 00 x1", r, nb);
        end
    endtask

    task automatic test_w_before_aw();
        logic [1:0] r; logic [N-1:0] p, pn; logic [N*DW-1:0] q;
        int lat, nb; bit tmo;
        do_write(32'h8, 32'h11223344, 4'h5, 3, 0, r, p, pn, q, lat, nb, tmo);
        model_write(32'h8, 32'h11223344, 4'h5);
        checks++;
        if (q[2*DW +: DW] !== 32'hDE22BE44 || q !== model_flat()) begin
            errors++;
            $display("FAIL w_first_reg2 got %h want de22be44", q[2*DW +: DW]);
        end
        checks++;
        if (tmo || nb !== 1 || lat !== 5 || r !== 2'b00) begin
            errors++;
            $display("FAIL w_first_b got count %0d lat %0d resp %b want 1 5 00",
                     nb, lat, r);
        end
    endtask

    task automatic test_read_hold();
        logic [DW-1:0] d; logic [1:0] r; int lat; bit st, tmo;
        logic arv, ara;
        do_read(32'h8, 5, d, r, lat, st, arv, ara, tmo);
        checks++;
        if (tmo || d !== model[2] || r !== 2'b00 || lat !== 1) begin
            errors++;
            $display("FAIL read_hold_data got %h resp %b lat %0d want %h 00 1",
                     d, r, lat, model[2]);
        end
        checks++;
        if (!st) begin
            errors++;
            $display("FAIL read_hold_stable got unstable want stable");
        end
        checks++;
        if (arv !== 1'b0 || ara !== 1'b1) begin
            errors++;
            $display("FAIL read_release got rvalid %b arready %b want 0 1",
                     arv, ara);
        end
    endtask

    task automatic test_read_before_write();
        logic [1:0] r; logic [N-1:0] p, pn; logic [N*DW-1:0] q;
        logic [DW-1:0] old;
        int lat, nb; bit tmo;
        do_write(32'h4, 32'hAA, 4'hF, 0, 0, r, p, pn, q, lat, nb, tmo);
        model_write(32'h4, 32'hAA, 4'hF);
        old = model[1];
        awvalid = 1'b1; awaddr = 32'h4;
        wvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF; bready = 1'b1;
        @(negedge clock);
        awvalid = 1'b0; wvalid = 1'b0;
        arvalid = 1'b1; araddr = 32'h4; rready = 1'b0;
        @(negedge clock);
        arvalid = 1'b0;
        model_write(32'h4, 32'h55, 4'hF);
        checks++;
        if (rvalid !== 1'b1 || rdata !== old || old !== 32'hAA) begin
            errors++;
            $display("FAIL rbw_rdata got %h rvalid %b want %h", rdata, rvalid, old);
        end
        checks++;
        if (reg_q[1*DW +: DW] !== 32'h55 || bvalid !== 1'b1) begin
            errors++;
            $display("FAIL rbw_reg1 got %h bvalid %b want 55 1",
                     reg_q[1*DW +: DW], bvalid);
        end
        rready = 1'b1;
        @(negedge clock);
        rready = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_out_of_range();
        logic [1:0] r; logic [N-1:0] p, pn; logic [N*DW-1:0] q;
        logic [DW-1:0] d; int lat, nb; bit tmo, st; logic arv, ara;
        do_write(32'h40, $urandom, 4'hF, 0, 0, r, p, pn, q, lat, nb, tmo);
        checks++;
        if (tmo || r !== OOR_RESP || nb !== 1) begin
            errors++;
            $display("FAIL oor_write_resp got %b count %0d want %b x1",
                     r, nb, OOR_RESP);
        end
        checks++;
        if (p !== '0 || q !== model_flat()) begin
            errors++;
            $display("FAIL oor_write_effect got pulse %h want 0 and no change", p);
        end
        do_read(32'h40, 0, d, r, lat, st, arv, ara, tmo);
        checks++;
        if (tmo || d !== '0 || r !== OOR_RESP) begin
            errors++;
            $display("FAIL oor_read got %h resp %b want 0 %b", d, r, OOR_RESP);
        end
    endtask

    task automatic test_random(input int ops);
        logic [1:0] r; logic [N-1:0] p, pn; logic [N*DW-1:0] q;
        logic [DW-1:0] d, ed; logic [AW-1:0] a; logic [3:0] s;
        int lat, nb, lead, el; bit tmo, st; logic arv, ara;
        for (int k = 0; k < ops; k++) begin
            a = rand_addr();
            if ($urandom_range(0, 2) != 0) begin
                d = $urandom;
                s = 4'($urandom_range(0, 15));
                lead = $urandom_range(0, 6) - 3;
                el = ((lead < 0) ? -lead : lead) + 2;
                do_write(a, d, s, lead, $urandom_range(0, 3),
                         r, p, pn, q, lat, nb, tmo);
                model_write(a, d, s);
                checks++;
                if (tmo || nb !== 1 || lat !== el) begin
                    errors++;
                    $display("FAIL rnd_wr_b a=%h got count %0d lat %0d want 1 %0d",
                             a, nb, lat, el);
                end
                checks++;
                if (r !== (in_range(a) ? 2'b00 : OOR_RESP)) begin
                    errors++;
                    $display("FAIL rnd_wr_resp a=%h got %b", a, r);
                end
                checks++;
                if (p !== exp_pulse(a) || pn !== '0) begin
                    errors++;
                    $display("FAIL rnd_wr_pulse a=%h got %h then %h want %h then 0",
                             a, p, pn, exp_pulse(a));
                end
                checks++;
                if (q !== model_flat()) begin
                    errors++;
                    $display("FAIL rnd_wr_regs a=%h d=%h s=%h got mismatching reg_q",
                             a, d, s);
                end
            end else begin
                ed = in_range(a) ? model[idx_of(a)] : '0;
                do_read(a, $urandom_range(0, 3), d, r, lat, st, arv, ara, tmo);
                checks++;
                if (tmo || d !== ed || lat !== 1 || !st) begin
                    errors++;
                    $display("FAIL rnd_rd a=%h got %h lat %0d stable %0d want %h",
                             a, d, lat, st, ed);
                end
                checks++;
                if (r !== (in_range(a) ? 2'b00 : OOR_RESP) ||
                    arv !== 1'b0 || ara !== 1'b1) begin
                    errors++;
                    $display("FAIL rnd_rd_resp a=%h got %b rv %b ar %b", a, r, arv, ara);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        awvalid = 1'b1; awaddr = 32'hC;
        wvalid = 1'b1; wdata = 32'hCAFE0001; wstrb = 4'hF; bready = 1'b0;
        arvalid = 1'b1; araddr = 32'h8; rready = 1'b0;
        @(negedge clock);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if (bvalid !== 1'b1 || rvalid !== 1'b1 || reg_q === '0) begin
            errors++;
            $display("FAIL mid_pre got bvalid %b rvalid %b want 1 1", bvalid, rvalid);
        end
        #2 resetn = 1'b0;
        #1;
        for (int i = 0; i < N; i++) model[i] = '0;
        checks++;
        if (bvalid !== 1'b0 || rvalid !== 1'b0 || reg_q !== model_flat()) begin
            errors++;
            $display("FAIL mid_async got bvalid %b rvalid %b want 0 0 regs 0",
                     bvalid, rvalid);
        end
        checks++;
        if ({awready, wready, arready} !== 3'b000) begin
            errors++;
            $display("FAIL mid_ready_low got %b want 000", {awready, wready, arready});
        end
        bready = 1'b1;
        repeat (2) @(negedge clock);
        resetn = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({awready, wready, arready} !== 3'b111) begin
            errors++;
            $display("FAIL mid_ready_after got %b want 111",
                     {awready, wready, arready});
        end
        @(negedge clock);
    endtask

    initial begin
        for (int i = 0; i < N; i++) model[i] = '0;
        test_reset();
        test_same_cycle();
        test_w_before_aw();
        test_read_hold();
        test_read_before_write();
        test_out_of_range();
        test_random(60);
        test_reset_mid();
        test_random(10);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
